alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/ctz_nibble.sv | 20 ++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings, widths, FSM state type and combinational ALU function for alu_exec_unit.
// ALU_CTZ_EN adds the SCAN state and nibble-counter widths.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CTL_W = 4;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned TZ_W  = 2;

    localparam logic [CTL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'b0010;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [CTL_W-1:0] ALU_CTZ = 4'b0100;

`ifdef ALU_CTZ_EN
    localparam int unsigned NIBBLES = XLEN / NIB_W;
    localparam int unsigned K_W     = $clog2(NIBBLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } alu_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0
    } alu_state_e;
`endif

    // Single-cycle ops; CTZ and undefined codes fall through to ADD.
    function automatic logic [XLEN-1:0] alu_calc(
        input logic [CTL_W-1:0] ctl,
        input logic [XLEN-1:0]  a,
        input logic [XLEN-1:0]  b
    );
        logic [XLEN-1:0] r;
        case (ctl)
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
            ALU_OR:  r = a | b;
            ALU_ADD,
            ALU_CTZ: r = a + b;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctz_nibble.sv
// Trailing-zero count (0..3) of one nibble plus a nonzero flag.
module ctz_nibble
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [TZ_W-1:0]  tz_c,
    output logic             nz_c
);

    always_comb begin
        tz_c = TZ_W'(0);
        if (nib[0])      tz_c = TZ_W'(0);
        else if (nib[1]) tz_c = TZ_W'(1);
        else if (nib[2]) tz_c = TZ_W'(2);
        else if (nib[3]) tz_c = TZ_W'(3);
    end

    assign nz_c = |nib;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/SLT/OR, optional multi-cycle CTZ nibble scan.
// Define ALU_CTZ_EN to enable the CTZ SCAN state; otherwise CTZ executes as ADD.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             out_valid,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             busy
);

    alu_state_e      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            accept_c;

`ifdef ALU_CTZ_EN
    logic [K_W-1:0]   k_q, k_d;
    logic [XLEN-1:0]  scan_q, scan_d;
    logic [NIB_W-1:0] nib_c;
    logic [TZ_W-1:0]  tz_c;
    logic             nz_c;

    assign nib_c = scan_q[{k_q, 2'b00} +: NIB_W];

    ctz_nibble u_ctz_nibble (
        .nib  (nib_c),
        .tz_c (tz_c),
        .nz_c (nz_c)
    );
`endif

    assign accept_c = in_valid && in_ready && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
`ifdef ALU_CTZ_EN
            k_q         <= '0;
            scan_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
`ifdef ALU_CTZ_EN
            k_q         <= k_d;
            scan_q      <= scan_d;
`endif
        end
    end

    // Next-state and result datapath.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
`ifdef ALU_CTZ_EN
        k_d         = k_q;
        scan_d      = scan_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
`ifdef ALU_CTZ_EN
                    if (alu_ctl == ALU_CTZ) begin
                        state_d = ST_SCAN;
                        k_d     = '0;
                        scan_d  = op_a;
                    end else
`endif
                    begin
                        out_valid_d = 1'b1;
                        result_d    = alu_calc(alu_ctl, op_a, op_b);
                        zero_d      = (result_d == '0);
                    end
                end
            end
`ifdef ALU_CTZ_EN
            ST_SCAN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (nz_c || (k_q == K_W'(NIBBLES - 1))) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = nz_c ? XLEN'({k_q, tz_c}) : XLEN'(XLEN);
                    zero_d      = (result_d == '0);
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
`ifdef ALU_CTZ_EN
    assign busy      = (state_q == ST_SCAN);
`else
    assign busy      = 1'b0;
`endif

endmodule
